// File: rtl/superalu_arb_pkg.sv
// Shared types and constants for the SHARE_SUPERALU round-robin sequencer.
package superalu_arb_pkg;

    localparam int DATA_W_DEF  = 13;
    localparam int TYPE_W_DEF  = 4;
    localparam int MODE_W_DEF  = 2;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // One-hot ALU operation select.
    localparam logic [3:0] ALU_MULTIPLY = 4'b1000;
    localparam logic [3:0] ALU_DIVISION = 4'b0100;
    localparam logic [3:0] ALU_SQRTPOWS = 4'b0010;

    localparam logic [1:0] MODE_MULTI_PURE = 2'b00;
    localparam logic [1:0] MODE_SA_DIV     = 2'b00;
    localparam logic [1:0] MODE_MULTI_FRAC = 2'b01;
    localparam logic [1:0] MODE_CF_T27     = 2'b01;
    localparam logic [1:0] MODE_MULTI_MAXM = 2'b10;
    localparam logic [1:0] MODE_CF_T36     = 2'b10;

endpackage

// File: rtl/superalu_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win,
    output logic       any
);

    always_comb begin
        // NOTE: default assignment first, so no path through the case can infer a latch.
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/superalu_arbiter.sv
// Shares one SHARE_SUPERALU between two requesters: grant, start pulse, capture, done pulse.
// Define SUPERALU_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles with err.
module superalu_arbiter
    import superalu_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TYPE_W  = TYPE_W_DEF,
    parameter int MODE_W  = MODE_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,

    input  logic [1:0]          req,
    input  logic [2*DATA_W-1:0] req_x,
    input  logic [2*DATA_W-1:0] req_y,
    input  logic [2*TYPE_W-1:0] req_type,
    input  logic [2*MODE_W-1:0] req_mode,

    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [1:0]          err,
    output logic [DATA_W-1:0]   res_f,
    output logic [DATA_W-1:0]   res_p,

    output logic [DATA_W-1:0]   alu_x,
    output logic [DATA_W-1:0]   alu_y,
    output logic [TYPE_W-1:0]   alu_type,
    output logic [MODE_W-1:0]   alu_mode,
    output logic                alu_start,
    input  logic                alu_is_done,
    input  logic [DATA_W-1:0]   alu_fout,
    input  logic [DATA_W-1:0]   alu_pout
);

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("superalu_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_e        state_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              alu_start_q;
    logic [DATA_W-1:0] alu_x_q;
    logic [DATA_W-1:0] alu_y_q;
    logic [TYPE_W-1:0] alu_type_q;
    logic [MODE_W-1:0] alu_mode_q;
    logic [DATA_W-1:0] res_f_q;
    logic [DATA_W-1:0] res_p_q;
    logic              last_q;

    logic [1:0]        pick_win;
    logic              pick_any;

    logic [DATA_W-1:0] alu_x_d;
    logic [DATA_W-1:0] alu_y_d;
    logic [TYPE_W-1:0] alu_type_d;
    logic [MODE_W-1:0] alu_mode_d;

    logic              done_qual;

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .win  (pick_win),
        .any  (pick_any)
    );

    always_comb begin
        alu_x_d    = req_x[0 +: DATA_W];
        alu_y_d    = req_y[0 +: DATA_W];
        alu_type_d = req_type[0 +: TYPE_W];
        alu_mode_d = req_mode[0 +: MODE_W];
        if (pick_win[1]) begin
            alu_x_d    = req_x[DATA_W +: DATA_W];
            alu_y_d    = req_y[DATA_W +: DATA_W];
            alu_type_d = req_type[TYPE_W +: TYPE_W];
            alu_mode_d = req_mode[MODE_W +: MODE_W];
        end
    end

    // alu_start_q is high exactly during the first WAIT cycle, so it masks a stale done level.
    assign done_qual = alu_is_done & ~alu_start_q;

`ifdef SUPERALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [1:0]       err_q;
    logic             timeout_hit;

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_q <= '0;
        end else if ((state_q == ST_WAIT) && !done_qual && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            alu_start_q <= 1'b0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_type_q  <= '0;
            alu_mode_q  <= '0;
            res_f_q     <= '0;
            res_p_q     <= '0;
            last_q      <= 1'b1;
`ifdef SUPERALU_ARB_TIMEOUT_EN
            err_q       <= 2'b00;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch sees start-of-cycle register values.
            done_q      <= 2'b00;
            alu_start_q <= 1'b0;
`ifdef SUPERALU_ARB_TIMEOUT_EN
            err_q       <= 2'b00;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        alu_x_q    <= alu_x_d;
                        alu_y_q    <= alu_y_d;
                        alu_type_q <= alu_type_d;
                        alu_mode_q <= alu_mode_d;
                        gnt_q      <= pick_win;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_start_q <= 1'b1;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_qual) begin
                        res_f_q <= alu_fout;
                        res_p_q <= alu_pout;
                        done_q  <= gnt_q;
                        gnt_q   <= 2'b00;
                        state_q <= ST_DONE;
                    end
`ifdef SUPERALU_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        res_f_q <= '0;
                        res_p_q <= '0;
                        done_q  <= gnt_q;
                        err_q   <= gnt_q;
                        gnt_q   <= 2'b00;
                        state_q <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    last_q  <= done_q[1];
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign res_f     = res_f_q;
    assign res_p     = res_p_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_type  = alu_type_q;
    assign alu_mode  = alu_mode_q;
    assign alu_start = alu_start_q;

`ifdef SUPERALU_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_superalu_arbiter.sv
// Randomized bench for superalu_arbiter: the bench acts as both requesters and the ALU.
module tb_superalu_arbiter;
    import superalu_arb_pkg::*;

    localparam int DW = 13;
    localparam int TW = 4;
    localparam int MW = 2;
    localparam int TO = 8;
`ifdef SUPERALU_ARB_TIMEOUT_EN
    localparam int K_LONG = TO;
    localparam int K_MAX  = TO;
`else
    localparam int K_LONG = 20;
    localparam int K_MAX  = 12;
`endif

    logic           CLK   = 1'b0;
    logic           RST_N = 1'b1;
    logic [1:0]     req   = 2'b00;
    logic [2*DW-1:0] req_x;
    logic [2*DW-1:0] req_y;
    logic [2*TW-1:0] req_type;
    logic [2*MW-1:0] req_mode;
    logic [1:0]     gnt, done, err;
    logic [DW-1:0]  res_f, res_p;
    logic [DW-1:0]  alu_x, alu_y;
    logic [TW-1:0]  alu_type;
    logic [MW-1:0]  alu_mode;
    logic           alu_start;
    logic           alu_is_done = 1'b0;
    logic [DW-1:0]  alu_fout    = '0;
    logic [DW-1:0]  alu_pout    = '0;

    logic [DW-1:0]  op_x [2];
    logic [DW-1:0]  op_y [2];
    logic [TW-1:0]  op_t [2];
    logic [MW-1:0]  op_m [2];

    assign req_x    = {op_x[1], op_x[0]};
    assign req_y    = {op_y[1], op_y[0]};
    assign req_type = {op_t[1], op_t[0]};
    assign req_mode = {op_m[1], op_m[0]};

    // Transaction-level reference state.
    int            last_served;
    bit            in_done;
    logic [DW-1:0] exp_f, exp_p;
    int            n_checks = 0;
    int            n_errors = 0;

    superalu_arbiter #(
        .DATA_W (DW), .TYPE_W (TW), .MODE_W (MW), .TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_type    (req_type),
        .req_mode    (req_mode),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .res_f       (res_f),
        .res_p       (res_p),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_type    (alu_type),
        .alu_mode    (alu_mode),
        .alu_start   (alu_start),
        .alu_is_done (alu_is_done),
        .alu_fout    (alu_fout),
        .alu_pout    (alu_pout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 2; i++) begin
            op_x[i] = DW'($urandom);
            op_y[i] = DW'($urandom);
            op_t[i] = TW'($urandom);
            op_m[i] = MW'($urandom);
        end
    endtask

    task automatic apply_reset();
        RST_N       = 1'b0;
        req         = 2'b00;
        alu_is_done = 1'b0;
        #3;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_start", alu_start, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_y", alu_y, 0);
        check("rst_opcode", {alu_type, alu_mode}, 0);
        check("rst_res_f", res_f, 0);
        check("rst_res_p", res_p, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("rel_idle", {done, gnt, alu_start}, 0);
        last_served = 1;
        in_done     = 1'b0;
        exp_f       = '0;
        exp_p       = '0;
    endtask

    task automatic sync_idle();
        if (in_done) begin
            req = 2'b00;
            tick();
            check("sync_idle", {err, done, gnt, alu_start}, 0);
            in_done = 1'b0;
        end
    endtask

    // One full transaction; the ALU raises done so it is captured k cycles after the start edge.
    task automatic do_op(input logic [1:0] pat, input int k, input bit stale, input bit drop);
        int            w;
        logic [1:0]    w_oh;
        logic [DW-1:0] ex, ey, fx, fy;
        logic [TW-1:0] et;
        logic [MW-1:0] em;
        req = pat;
        if (in_done) begin
            tick();
            check("idle_busy", {err, done, gnt, alu_start}, 0);
            check("idle_res_f", res_f, exp_f);
            check("idle_res_p", res_p, exp_p);
        end
        w    = (pat == 2'b11) ? (1 - last_served) : (pat[1] ? 1 : 0);
        w_oh = 2'b01 << w;
        ex = op_x[w];
        ey = op_y[w];
        et = op_t[w];
        em = op_m[w];
        alu_is_done = stale;
        alu_fout    = DW'($urandom);
        alu_pout    = DW'($urandom);
        tick();
        check("gnt", gnt, w_oh);
        check("alu_x", alu_x, ex);
        check("alu_y", alu_y, ey);
        check("opcode", {alu_type, alu_mode}, {et, em});
        check("grant_quiet", {done, alu_start}, 0);
        if (drop) req[w] = 1'b0;
        tick();
        check("start", {alu_start, gnt}, {1'b1, w_oh});
        tick();
        check("blank", {done, gnt, alu_start}, {2'b00, w_oh, 1'b0});
        check("hold_res_f", res_f, exp_f);
        for (int j = 3; j <= k; j++) begin
            alu_is_done = 1'b0;
            alu_fout    = DW'($urandom);
            alu_pout    = DW'($urandom);
            tick();
            check("wait_busy", {done, gnt, alu_start}, {2'b00, w_oh, 1'b0});
        end
        fx = DW'($urandom);
        fy = DW'($urandom);
        alu_fout    = fx;
        alu_pout    = fy;
        alu_is_done = 1'b1;
        tick();
        check("done", done, w_oh);
        check("done_gnt", gnt, 0);
        check("done_err", err, 0);
        check("res_f", res_f, fx);
        check("res_p", res_p, fy);
        exp_f       = fx;
        exp_p       = fy;
        last_served = w;
        in_done     = 1'b1;
        alu_is_done = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [1:0] pat;
        randomize_ops();
        #1;
        apply_reset();

        // Single request with the documented operands.
        op_x[0] = 13'h0F0;
        op_y[0] = 13'h06A;
        op_t[0] = ALU_MULTIPLY;
        op_m[0] = MODE_MULTI_FRAC;
        do_op(2'b01, K_LONG, 1'b0, 1'b0);

        // Tie straight after reset, then sustained contention with a stale done level.
        apply_reset();
        randomize_ops();
        do_op(2'b11, 3, 1'b0, 1'b0);
        do_op(2'b11, 2, 1'b0, 1'b0);
        do_op(2'b11, 4, 1'b1, 1'b0);
        do_op(2'b11, 2, 1'b1, 1'b0);

        sync_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_req_idle", {gnt, alu_start}, 0);
        end

        for (int i = 0; i < 40; i++) begin
            randomize_ops();
            pat = 2'($urandom_range(1, 3));
            do_op(pat, int'($urandom_range(2, K_MAX)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end

        // ALU that never answers.
        sync_idle();
        randomize_ops();
        req         = 2'b01;
        alu_is_done = 1'b0;
        alu_fout    = DW'($urandom) | DW'(1);
        alu_pout    = DW'($urandom) | DW'(1);
        tick();
        check("to_gnt", gnt, 2'b01);
        req = 2'b00;
        tick();
        check("to_start", alu_start, 1);
`ifdef SUPERALU_ARB_TIMEOUT_EN
        for (int j = 0; j < TO - 1; j++) begin
            tick();
            check("to_wait", {done, err, gnt}, {4'b0000, 2'b01});
        end
        tick();
        check("to_done", done, 2'b01);
        check("to_err", err, 2'b01);
        check("to_gnt_clr", gnt, 0);
        check("to_res_f", res_f, 0);
        check("to_res_p", res_p, 0);
        exp_f       = '0;
        exp_p       = '0;
        last_served = 0;
        in_done     = 1'b1;
`else
        for (int j = 0; j < 40; j++) begin
            tick();
            check("hang_wait", {done, err, gnt}, {4'b0000, 2'b01});
        end
        apply_reset();
`endif

        // Reset in the middle of WAIT, then a clean restart and a dropped request.
        sync_idle();
        randomize_ops();
        req         = 2'b10;
        alu_is_done = 1'b0;
        tick();
        check("mw_gnt", gnt, 2'b10);
        tick();
        tick();
        tick();
        check("mw_busy", {done, gnt}, {2'b00, 2'b10});
        apply_reset();
        randomize_ops();
        do_op(2'b11, 3, 1'b0, 1'b0);
        do_op(2'b01, 2, 1'b0, 1'b1);
        do_op(2'b10, 5, 1'b1, 1'b1);
        sync_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
